// File: rtl/ntt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ntt_ctrl
// Description : Stage/butterfly sequencer for a radix-2 in-place NTT.
//               Issues one butterfly per cycle, drives two conflict-free
//               memory banks, the twiddle ROM address and the output-network
//               route selects, and inserts a BF_LAT drain gap between
//               stages. The write side is the read side delayed by BF_LAT.
//               Optional feature macro: NTT_CTRL_INTT_EN (adds inv/bf_mode
//               and Gentleman-Sande addressing for inverse transforms).
// Revision    : 1.0 - initial release
// ============================================================================
module ntt_ctrl #(
    parameter int LOGN   = 8,
    parameter int BF_LAT = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
`ifdef NTT_CTRL_INTT_EN
    input  logic            inv,
    output logic            bf_mode,
`endif
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [LOGN-2:0] rd_addr0,
    output logic [LOGN-2:0] rd_addr1,
    output logic [LOGN-1:0] tw_addr,
    output logic            sel_a_0,
    output logic            sel_a_1,
    output logic            wr_en,
    output logic [LOGN-2:0] wr_addr0,
    output logic [LOGN-2:0] wr_addr1
);

    localparam int c_SW = $clog2(LOGN);
    localparam int c_CW = $clog2(BF_LAT + 1);
    localparam int c_DW = 2 * LOGN - 1;

    localparam logic [c_SW-1:0] c_S_LAST     = c_SW'(LOGN - 1);
    localparam logic [LOGN-2:0] c_J_LAST     = '1;
    localparam logic [c_CW-1:0] c_DRAIN_LAST = c_CW'(BF_LAT - 1);
    localparam logic [LOGN-1:0] c_ONE        = LOGN'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [c_SW-1:0] r_s, w_s_nxt;
    logic [LOGN-2:0] r_j, w_j_nxt;
    logic [c_CW-1:0] r_cnt, w_cnt_nxt;
    logic            w_inv_nxt;
    logic            w_accept;

    assign w_accept = (r_state == ST_IDLE) && start;

`ifdef NTT_CTRL_INTT_EN
    logic r_inv;

    // Capture the transform direction when a request is accepted
    always_ff @(posedge clk) begin
        if (rst) r_inv <= 1'b0;
        else     r_inv <= w_inv_nxt;
    end

    assign w_inv_nxt = w_accept ? inv : r_inv;
`else
    assign w_inv_nxt = 1'b0;
`endif

    // State and loop-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_j     <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_j     <= w_j_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: issue N/2 butterflies, drain BF_LAT cycles, repeat per stage
    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_j_nxt     = r_j;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_ISSUE;
                    w_s_nxt     = '0;
                    w_j_nxt     = '0;
                end
            end
            ST_ISSUE: begin
                if (r_j == c_J_LAST) begin
                    w_state_nxt = ST_DRAIN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_j_nxt = r_j + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (r_cnt == c_DRAIN_LAST) begin
                    if (r_s == c_S_LAST) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_ISSUE;
                        w_s_nxt     = r_s + 1'b1;
                        w_j_nxt     = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Butterfly addressing for the upcoming cycle; forward and inverse
    // orders differ only in which shift sets the span and twiddle base
    logic [c_SW-1:0] w_dsh, w_tsh;
    logic [LOGN-1:0] w_jx, w_d, w_g, w_k, w_up, w_lo, w_tw;
    logic [LOGN-2:0] w_up_ba, w_lo_ba;
    logic            w_bank_up;

    always_comb begin
        w_dsh     = w_inv_nxt ? w_s_nxt : (c_S_LAST - w_s_nxt);
        w_tsh     = w_inv_nxt ? (c_S_LAST - w_s_nxt) : w_s_nxt;
        w_jx      = {1'b0, w_j_nxt};
        w_d       = c_ONE << w_dsh;
        w_g       = w_jx >> w_dsh;
        w_k       = w_jx & (w_d - c_ONE);
        w_up      = ((w_g << w_dsh) << 1) | w_k;
        w_lo      = w_up | w_d;
        w_tw      = (c_ONE << w_tsh) + w_g;
        w_bank_up = ^w_up;
        w_up_ba   = (LOGN-1)'(w_up >> 1);
        w_lo_ba   = (LOGN-1)'(w_lo >> 1);
    end

    logic w_busy_nxt;
    logic w_issue_nxt;

    assign w_busy_nxt  = (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_DRAIN);
    assign w_issue_nxt = (w_state_nxt == ST_ISSUE);

    // Registered handshake and read-side outputs, zeroed outside issue cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_en    <= 1'b0;
            rd_addr0 <= '0;
            rd_addr1 <= '0;
            tw_addr  <= '0;
            sel_a_0  <= 1'b0;
            sel_a_1  <= 1'b0;
`ifdef NTT_CTRL_INTT_EN
            bf_mode  <= 1'b0;
`endif
        end else begin
            busy  <= w_busy_nxt;
            done  <= (w_state_nxt == ST_DONE);
            rd_en <= w_issue_nxt;
`ifdef NTT_CTRL_INTT_EN
            bf_mode <= w_busy_nxt & w_inv_nxt;
`endif
            if (w_issue_nxt) begin
                rd_addr0 <= w_bank_up ? w_lo_ba : w_up_ba;
                rd_addr1 <= w_bank_up ? w_up_ba : w_lo_ba;
                tw_addr  <= w_tw;
                sel_a_0  <= ~w_bank_up;
                sel_a_1  <= w_bank_up;
            end else begin
                rd_addr0 <= '0;
                rd_addr1 <= '0;
                tw_addr  <= '0;
                sel_a_0  <= 1'b0;
                sel_a_1  <= 1'b0;
            end
        end
    end

    // Write-side delay line: in-place writes reuse the read bank addresses
    logic [c_DW-1:0] r_dly [BF_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BF_LAT; i++) r_dly[i] <= '0;
        end else begin
            r_dly[0] <= {rd_en, rd_addr0, rd_addr1};
            for (int i = 1; i < BF_LAT; i++) r_dly[i] <= r_dly[i-1];
        end
    end

    assign {wr_en, wr_addr0, wr_addr1} = r_dly[BF_LAT-1];

endmodule
`default_nettype wire
